sand_frame_engine: RTL and testbench

- Sequential successor to the per-row sand update logic. Walks the whole cell framebuffer once per `start` and applies falling-sand physics to every (region row, floor row) pair, bottom-up.
- Cell packing width, words per row and row count are parameters.
- New over the row-pair update: grains move diagonally across word boundaries, the diagonal preference alternates, and the block owns its memory-access state machine.
- Sits between the frame-tick controller and the dual-port cell RAM that the VGA renderer also reads.

---
 rtl/sand_pkg.sv | 36 +++
 rtl/sand_word_resolve.sv | 82 ++++++++
 rtl/sand_frame_engine.sv | 195 +++++++++++++++++++
 tb/tb_sand_frame_engine.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sand_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sand_pkg
// Purpose  : Shared cell codes, engine states and RAM address helper for the
//            falling-sand frame engine.
// Revision : 1.0
// ============================================================================
package sand_pkg;

    localparam int CELL_W = 2;

    typedef enum logic [1:0] {
        AIR     = 2'd0,
        SAND    = 2'd1,
        SAND_AM = 2'd2,
        WALL    = 2'd3
    } cell_t;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RD_F0   = 4'd1,
        S_RD_REG  = 4'd2,
        S_RD_FN   = 4'd3,
        S_RESOLVE = 4'd4,
        S_WR_REG  = 4'd5,
        S_WR_FL   = 4'd6,
        S_ROW_END = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    function automatic int addr_of(input int row, input int wrd, input int words_per_row);
        return row * words_per_row + wrd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sand_word_resolve.sv
`default_nettype none
// ============================================================================
// Module   : sand_word_resolve
// Purpose  : Combinational falling-sand update of one region word against a
//            three-word floor window (left, centre, right).
// Revision : 1.0
// ============================================================================
module sand_word_resolve
    import sand_pkg::*;
#(
    parameter int CELLS_PER_WORD = 16
) (
    input  logic [CELL_W*CELLS_PER_WORD-1:0] i_region,
    input  logic [CELL_W*CELLS_PER_WORD-1:0] i_fl_prev,
    input  logic [CELL_W*CELLS_PER_WORD-1:0] i_fl_cur,
    input  logic [CELL_W*CELLS_PER_WORD-1:0] i_fl_next,
    input  logic                             i_bias,
    input  logic                             i_is_first_word,
    input  logic                             i_is_last_word,
    output logic [CELL_W*CELLS_PER_WORD-1:0] o_new_region,
    output logic [CELL_W*CELLS_PER_WORD-1:0] o_new_prev,
    output logic [CELL_W*CELLS_PER_WORD-1:0] o_new_cur,
    output logic [CELL_W*CELLS_PER_WORD-1:0] o_new_next
);

    localparam int c_N = CELLS_PER_WORD;

    // Floor cells flattened left to right: prev word, centre word, next word.
    logic [3*c_N-1:0][CELL_W-1:0] w_fl;
    logic [c_N-1:0][CELL_W-1:0]   w_reg;
    logic                         w_l_ok;
    logic                         w_r_ok;

    always_comb begin
        w_fl         = '0;
        w_reg        = '0;
        w_l_ok       = 1'b0;
        w_r_ok       = 1'b0;
        o_new_region = '0;
        o_new_prev   = '0;
        o_new_cur    = '0;
        o_new_next   = '0;

        for (int k = 0; k < c_N; k++) begin
            w_fl[k]         = i_fl_prev[CELL_W*(c_N-1-k) +: CELL_W];
            w_fl[c_N+k]     = i_fl_cur [CELL_W*(c_N-1-k) +: CELL_W];
            w_fl[2*c_N+k]   = i_fl_next[CELL_W*(c_N-1-k) +: CELL_W];
            w_reg[k]        = i_region [CELL_W*(c_N-1-k) +: CELL_W];
        end

        // Ascending column order so later cells see earlier landings.
        for (int k = 0; k < c_N; k++) begin
            if (w_reg[k] == SAND_AM) begin
                w_reg[k] = SAND;
            end else if (w_reg[k] == SAND) begin
                if (w_fl[c_N+k] == AIR) begin
                    w_fl[c_N+k] = SAND_AM;
                    w_reg[k]    = AIR;
                end else begin
                    w_l_ok = !(i_is_first_word && (k == 0)) && (w_fl[c_N+k-1] == AIR);
                    w_r_ok = !(i_is_last_word && (k == c_N-1)) && (w_fl[c_N+k+1] == AIR);
                    if (w_l_ok && (!i_bias || !w_r_ok)) begin
                        w_fl[c_N+k-1] = SAND_AM;
                        w_reg[k]      = AIR;
                    end else if (w_r_ok) begin
                        w_fl[c_N+k+1] = SAND_AM;
                        w_reg[k]      = AIR;
                    end
                end
            end
        end

        for (int k = 0; k < c_N; k++) begin
            o_new_prev  [CELL_W*(c_N-1-k) +: CELL_W] = w_fl[k];
            o_new_cur   [CELL_W*(c_N-1-k) +: CELL_W] = w_fl[c_N+k];
            o_new_next  [CELL_W*(c_N-1-k) +: CELL_W] = w_fl[2*c_N+k];
            o_new_region[CELL_W*(c_N-1-k) +: CELL_W] = w_reg[k];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sand_frame_engine.sv
`default_nettype none
// ============================================================================
// Module   : sand_frame_engine
// Purpose  : Walks the cell framebuffer bottom-up once per start and applies
//            falling-sand physics through a sliding three-word floor window.
// Revision : 1.0
// ============================================================================
module sand_frame_engine
    import sand_pkg::*;
#(
    parameter int CELLS_PER_WORD = 16,
    parameter int WORDS_PER_ROW  = 40,
    parameter int ROWS           = 480,
    parameter int ADDR_W         = 15
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             rd_en,
    output logic [ADDR_W-1:0]                rd_addr,
    input  logic [2*CELLS_PER_WORD-1:0]      rd_data,
    output logic                             wr_en,
    output logic [ADDR_W-1:0]                wr_addr,
    output logic [2*CELLS_PER_WORD-1:0]      wr_data
);

    localparam int c_WORD_BITS = CELL_W * CELLS_PER_WORD;
    localparam int c_ROW_W     = $clog2(ROWS + 1);
    localparam int c_WORD_W    = $clog2(WORDS_PER_ROW + 1);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [c_ROW_W-1:0]       r_row;
    logic [c_WORD_W-1:0]      r_word;
    logic                     r_bias;
    logic [c_WORD_BITS-1:0]   r_reg_word;
    logic [c_WORD_BITS-1:0]   r_fl_prev;
    logic [c_WORD_BITS-1:0]   r_fl_cur;
    logic [c_WORD_BITS-1:0]   r_fl_next;

    logic                     w_is_first;
    logic                     w_is_last;
    logic [c_WORD_BITS-1:0]   w_res_region;
    logic [c_WORD_BITS-1:0]   w_res_next;
    logic [c_WORD_BITS-1:0]   w_new_region;
    logic [c_WORD_BITS-1:0]   w_new_prev;
    logic [c_WORD_BITS-1:0]   w_new_cur;
    logic [c_WORD_BITS-1:0]   w_new_next;

    assign w_is_first = (r_word == '0);
    assign w_is_last  = (int'(r_word) == WORDS_PER_ROW - 1);

    // On the last word there is no RD_FN, so the region read lands in RESOLVE.
    assign w_res_region = w_is_last ? rd_data   : r_reg_word;
    assign w_res_next   = w_is_last ? r_fl_next : rd_data;

    sand_word_resolve #(
        .CELLS_PER_WORD (CELLS_PER_WORD)
    ) u_resolve (
        .i_region        (w_res_region),
        .i_fl_prev       (r_fl_prev),
        .i_fl_cur        (r_fl_cur),
        .i_fl_next       (w_res_next),
        .i_bias          (r_bias),
        .i_is_first_word (w_is_first),
        .i_is_last_word  (w_is_last),
        .o_new_region    (w_new_region),
        .o_new_prev      (w_new_prev),
        .o_new_cur       (w_new_cur),
        .o_new_next      (w_new_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_word     <= '0;
            r_bias     <= 1'b0;
            r_reg_word <= '0;
            r_fl_prev  <= '0;
            r_fl_cur   <= '0;
            r_fl_next  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row  <= c_ROW_W'(ROWS - 2);
                        r_word <= '0;
                    end
                end
                S_RD_REG: begin
                    if (w_is_first) r_fl_cur <= rd_data;
                end
                S_RD_FN: begin
                    r_reg_word <= rd_data;
                end
                S_RESOLVE: begin
                    r_reg_word <= w_new_region;
                    r_fl_prev  <= w_new_prev;
                    r_fl_cur   <= w_new_cur;
                    r_fl_next  <= w_new_next;
                end
                S_WR_REG: begin
                    if (w_is_first) begin
                        r_fl_prev <= r_fl_cur;
                        r_fl_cur  <= r_fl_next;
                        if (!w_is_last) r_word <= r_word + 1'b1;
                    end
                end
                S_WR_FL: begin
                    r_fl_prev <= r_fl_cur;
                    r_fl_cur  <= r_fl_next;
                    if (!w_is_last) r_word <= r_word + 1'b1;
                end
                S_ROW_END: begin
                    r_bias <= ~r_bias;
                    r_word <= '0;
                    if (r_row != '0) r_row <= r_row - 1'b1;
                end
                S_DONE: begin
                    r_bias <= ~r_bias;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = '0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;

        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_RD_F0;
            end
            S_RD_F0: begin
                rd_en        = 1'b1;
                rd_addr      = ADDR_W'(addr_of(int'(r_row) + 1, 0, WORDS_PER_ROW));
                w_next_state = S_RD_REG;
            end
            S_RD_REG: begin
                rd_en        = 1'b1;
                rd_addr      = ADDR_W'(addr_of(int'(r_row), int'(r_word), WORDS_PER_ROW));
                w_next_state = w_is_last ? S_RESOLVE : S_RD_FN;
            end
            S_RD_FN: begin
                rd_en        = 1'b1;
                rd_addr      = ADDR_W'(addr_of(int'(r_row) + 1, int'(r_word) + 1, WORDS_PER_ROW));
                w_next_state = S_RESOLVE;
            end
            S_RESOLVE: begin
                w_next_state = S_WR_REG;
            end
            S_WR_REG: begin
                wr_en   = 1'b1;
                wr_addr = ADDR_W'(addr_of(int'(r_row), int'(r_word), WORDS_PER_ROW));
                wr_data = r_reg_word;
                if (!w_is_first)     w_next_state = S_WR_FL;
                else if (w_is_last)  w_next_state = S_ROW_END;
                else                 w_next_state = S_RD_REG;
            end
            S_WR_FL: begin
                wr_en        = 1'b1;
                wr_addr      = ADDR_W'(addr_of(int'(r_row) + 1, int'(r_word) - 1, WORDS_PER_ROW));
                wr_data      = r_fl_prev;
                w_next_state = w_is_last ? S_ROW_END : S_RD_REG;
            end
            S_ROW_END: begin
                // The last floor word has been shifted into the prev slot.
                wr_en        = 1'b1;
                wr_addr      = ADDR_W'(addr_of(int'(r_row) + 1, WORDS_PER_ROW - 1, WORDS_PER_ROW));
                wr_data      = r_fl_prev;
                w_next_state = (r_row == '0) ? S_DONE : S_RD_F0;
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sand_frame_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sand_frame_engine
// Purpose  : Directed bench for sand_frame_engine with a 1-cycle RAM, a
//            whole-grid reference model and a write-stream scoreboard.
// Revision : 1.0
// ============================================================================
module tb_sand_frame_engine;

    localparam int CPW    = 4;
    localparam int WPR    = 2;
    localparam int NR     = 3;
    localparam int AW     = 3;
    localparam int DW     = 2 * CPW;
    localparam int COLS   = CPW * WPR;
    localparam int NWORDS = NR * WPR;

    localparam logic [1:0] C_AIR  = 2'd0;
    localparam logic [1:0] C_SAND = 2'd1;
    localparam logic [1:0] C_AM   = 2'd2;
    localparam logic [1:0] C_WALL = 2'd3;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] mem [0:NWORDS-1];

    logic [1:0]    grid [NR][COLS];
    bit            m_bias;
    wr_t           exp_q [$];
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    sand_frame_engine #(
        .CELLS_PER_WORD (CPW),
        .WORDS_PER_ROW  (WPR),
        .ROWS           (NR),
        .ADDR_W         (AW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
        else if (ld_en) mem[ld_addr] <= ld_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] cell_of(input int r, input int c);
        logic [DW-1:0] wd;
        wd = mem[r*WPR + c/CPW];
        return wd[2*(CPW-1-(c%CPW)) +: 2];
    endfunction

    function automatic logic [DW-1:0] pack_word(input int idx);
        logic [DW-1:0] wd;
        wd = '0;
        for (int k = 0; k < CPW; k++)
            wd[2*(CPW-1-k) +: 2] = grid[idx/WPR][(idx%WPR)*CPW + k];
        return wd;
    endfunction

    function automatic bit free_below(input int r, input int c);
        if (c < 0 || c >= COLS) return 1'b0;
        return grid[r+1][c] == C_AIR;
    endfunction

    task automatic push_exp(input int idx);
        wr_t e;
        e.a = AW'(idx);
        e.d = pack_word(idx);
        exp_q.push_back(e);
    endtask

    task automatic model_frame();
        int t1, t2;
        for (int r = NR-2; r >= 0; r--) begin
            for (int c = 0; c < COLS; c++) begin
                if (grid[r][c] == C_AM) begin
                    grid[r][c] = C_SAND;
                end else if (grid[r][c] == C_SAND) begin
                    t1 = m_bias ? c+1 : c-1;
                    t2 = m_bias ? c-1 : c+1;
                    if (free_below(r, c)) begin
                        grid[r+1][c] = C_AM; grid[r][c] = C_AIR;
                    end else if (free_below(r, t1)) begin
                        grid[r+1][t1] = C_AM; grid[r][c] = C_AIR;
                    end else if (free_below(r, t2)) begin
                        grid[r+1][t2] = C_AM; grid[r][c] = C_AIR;
                    end
                end
            end
            for (int w = 0; w < WPR; w++) begin
                push_exp(r*WPR + w);
                if (w > 0) push_exp((r+1)*WPR + w - 1);
            end
            push_exp((r+1)*WPR + WPR - 1);
            m_bias = ~m_bias;
        end
        m_bias = ~m_bias;
    endtask

    task automatic clear_grid();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < COLS; c++)
                grid[r][c] = C_AIR;
    endtask

    task automatic write_grid();
        for (int i = 0; i < NWORDS; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = AW'(i); ld_data = pack_word(i);
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); @(negedge clk); reset = 1'b0;
        m_bias = 1'b0;
        exp_q.delete();
    endtask

    task automatic run_frame(input int restart_at);
        wr_t e;
        int  cyc, quiet;
        bit  seen;
        model_frame();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 300) begin
            start = (cyc == restart_at);
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {21'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("write_%0d", cyc), {21'd0, wr_addr, wr_data}, {21'd0, e});
                end
            end
            if (done) seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("frame_done_seen", 32'(seen), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        check("writes_outstanding", exp_q.size(), 32'd0);
        exp_q.delete();
        quiet = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || wr_en || busy) quiet++;
        end
        check("quiet_after_done", quiet, 32'd0);
        for (int i = 0; i < NWORDS; i++)
            check($sformatf("mem_%0d", i), 32'(mem[i]), 32'(pack_word(i)));
    endtask

    initial begin
        int wcnt;
        reset = 1'b1; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; m_bias = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_rd_en",   32'(rd_en),   32'd0);
        check("rst_wr_en",   32'(wr_en),   32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        reset = 1'b0;

        // Straight fall: a moved grain rests one frame before falling again.
        clear_grid(); grid[0][2] = C_SAND; write_grid();
        run_frame(-1);
        check("fall1_r1c2", 32'(cell_of(1, 2)), 32'(C_AM));
        check("fall1_r0c2", 32'(cell_of(0, 2)), 32'(C_AIR));
        run_frame(-1);
        check("fall2_r1c2", 32'(cell_of(1, 2)), 32'(C_SAND));
        run_frame(-1);
        check("fall3_r2c2", 32'(cell_of(2, 2)), 32'(C_AM));
        check("fall3_row1w0", 32'(mem[2]), 32'h00);
        check("fall3_row1w1", 32'(mem[3]), 32'h00);

        // Diagonal preference.
        do_reset();
        clear_grid(); grid[1][1] = C_SAND; grid[2][1] = C_WALL; write_grid();
        run_frame(-1);
        check("diag_left", 32'(cell_of(2, 0)), 32'(C_AM));
        check("diag_left_src", 32'(cell_of(1, 1)), 32'(C_AIR));
        do_reset();
        clear_grid(); grid[1][1] = C_SAND; grid[2][1] = C_WALL; grid[2][0] = C_WALL; write_grid();
        run_frame(-1);
        check("diag_right", 32'(cell_of(2, 2)), 32'(C_AM));
        clear_grid(); grid[1][1] = C_SAND; grid[2][1] = C_WALL; write_grid();
        run_frame(-1);
        check("diag_bias1", 32'(cell_of(2, 2)), 32'(C_AM));
        check("diag_bias1_l", 32'(cell_of(2, 0)), 32'(C_AIR));

        // Cross-word diagonal.
        do_reset();
        clear_grid(); grid[1][3] = C_SAND; grid[2][3] = C_WALL; grid[2][2] = C_WALL; write_grid();
        run_frame(-1);
        check("xword_w0", 32'(mem[4]), 32'h0F);
        check("xword_w1", 32'(mem[5]), 32'h80);
        check("xword_src", 32'(mem[2]), 32'h00);

        // Screen edge: no wrap, grain stays.
        clear_grid(); grid[1][0] = C_SAND; grid[2][0] = C_WALL; grid[2][1] = C_WALL; write_grid();
        run_frame(-1);
        check("edge_stay", 32'(mem[2]), 32'h40);
        check("edge_walls", 32'(mem[4]), 32'hF0);

        // Conflict order with bias=1 at frame start.
        do_reset();
        clear_grid(); write_grid();
        run_frame(-1);
        clear_grid(); grid[1][1] = C_SAND; grid[1][3] = C_SAND;
        for (int c = 0; c < COLS; c++) grid[2][c] = C_WALL;
        grid[2][2] = C_AIR;
        write_grid();
        run_frame(-1);
        check("conf_region", 32'(mem[2]), 32'h01);
        check("conf_floor0", 32'(mem[4]), 32'hFB);
        check("conf_floor1", 32'(mem[5]), 32'hFF);

        // Mixed patterns, one with a start pulse while busy.
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < NR; r++)
                for (int c = 0; c < COLS; c++)
                    grid[r][c] = 2'($urandom_range(0, 3));
            write_grid();
            run_frame(t == 1 ? 6 : -1);
            run_frame(-1);
        end

        // Reset mid-frame aborts with no further writes.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
        check("busy_mid_frame", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("busy_after_abort", 32'(busy), 32'd0);
        wcnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (wr_en || busy) wcnt++;
        end
        check("writes_after_abort", wcnt, 32'd0);
        m_bias = 1'b0;

        // start coinciding with reset is ignored.
        reset = 1'b1; start = 1'b1;
        @(negedge clk); reset = 1'b0; start = 1'b0;
        check("start_during_reset", 32'(busy), 32'd0);
        @(negedge clk);
        check("start_during_reset2", 32'(busy), 32'd0);

        // Engine still works after the abort.
        clear_grid(); grid[0][5] = C_SAND; write_grid();
        run_frame(-1);
        check("post_abort_fall", 32'(cell_of(1, 5)), 32'(C_AM));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
